seg_bin_capture: RTL

Receiver for the 4-digit, time-multiplexed seven-segment bus that carries a 4-bit binary value, one bit per digit. It samples the active-low segment and anode lines and classifies each digit's pattern as 0, 1, blank or illegal. Per digit it requires a run of stable samples before committing, then rebuilds the 4-bit value. It sits on the display side of the lab board for loopback self-check and as a bench monitor.

---
 rtl/seg_bin_pkg.sv | 36 +++
 rtl/seg_bin_capture_filter.sv | 57 +++++
 rtl/seg_bin_capture.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_bin_pkg
// Purpose  : Shared symbol type, segment encodings and the pattern classifier
//            for the seven-segment binary capture block.
// Revision : 1.0 - initial release
// ============================================================================
package seg_bin_pkg;

  // Decoded meaning of one digit's segment pattern
  typedef enum logic [1:0] {
    SYM_ZERO  = 2'd0,
    SYM_ONE   = 2'd1,
    SYM_BLANK = 2'd2,
    SYM_BAD   = 2'd3
  } sym_t;

  // Active-low segment patterns, bit 7 = a ... bit 1 = g, bit 0 = dp
  localparam logic [7:0] SEG_ZERO  = 8'b00000011;
  localparam logic [7:0] SEG_ONE   = 8'b10011111;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Map a raw segment pattern onto a symbol; anything unrecognised is BAD
  function automatic sym_t classify(input logic [7:0] seg);
    sym_t s;
    case (seg)
      SEG_ZERO:  s = SYM_ZERO;
      SEG_ONE:   s = SYM_ONE;
      SEG_BLANK: s = SYM_BLANK;
      default:   s = SYM_BAD;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bin_capture_filter.sv
`default_nettype none
// ============================================================================
// Module   : seg_digit_filter
// Purpose  : Per-digit debounce. Tracks a candidate symbol and a saturating
//            run length; pulses commit once when the run reaches STABLE_CNT.
// Revision : 1.0 - initial release
// ============================================================================
module seg_digit_filter
  import seg_bin_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  sym_t sym,
  output logic commit,
  output sym_t sym_committed
);

  localparam int             CW    = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  c_sat = CW'(STABLE_CNT);

  sym_t          r_cand;
  logic [CW-1:0] r_cnt;
  logic          w_same;
  logic [CW-1:0] w_cnt_nxt;

  // Next run length: restart at 1 on a new symbol, otherwise count up to saturation
  always_comb begin
    w_same = (sym == r_cand);
    if (!w_same) begin
      w_cnt_nxt = CW'(1);
    end else if (r_cnt == c_sat) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Commit only on the sample that first reaches saturation, never while already saturated
  assign commit        = sample_en && (w_cnt_nxt == c_sat) && !(w_same && (r_cnt == c_sat));
  assign sym_committed = sym;

  // Candidate and run-length state, advanced only on this digit's qualified samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand <= SYM_BLANK;
      r_cnt  <= '0;
    end else if (sample_en) begin
      r_cand <= sym;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_bin_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_bin_capture
// Purpose  : Samples a 4-digit multiplexed active-low seven-segment bus,
//            debounces each digit and rebuilds the 4-bit value it displays.
// Revision : 1.0 - initial release
// ============================================================================
module seg_bin_capture
  import seg_bin_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg,
  input  logic [3:0] an,
  output logic [3:0] a,
  output logic       valid,
  output logic [3:0] err,
  output logic       update
);

  localparam int            SW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] c_settle = SW'(SETTLE);

  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic [SW-1:0] r_settle;
  logic          w_chg;
  sym_t          w_sym;
  logic [3:0]    w_sample;
  logic [3:0]    w_commit;
  sym_t          w_csym [4];

  logic [3:0]    r_a;
  logic [3:0]    r_ok;
  logic [3:0]    r_err;
  logic          r_update;
  logic [3:0]    w_a_nxt;
  logic [3:0]    w_ok_nxt;
  logic [3:0]    w_err_nxt;
  logic          w_upd_nxt;

  // A change is seen on the edge where the registered copy is about to differ
  assign w_chg = (seg != r_seg) || (an != r_an);
  assign w_sym = classify(r_seg);

  // Input register stage; reset value looks like an idle, blank bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= 8'hFF;
      r_an  <= 4'hF;
    end else begin
      r_seg <= seg;
      r_an  <= an;
    end
  end

  // Settle counter: reload on any bus change, then count down to zero and hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle <= c_settle;
    end else if (w_chg) begin
      r_settle <= c_settle;
    end else if (r_settle != '0) begin
      r_settle <= r_settle - SW'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_digit
    // Exactly this digit's anode low; any other pattern selects nothing
    localparam logic [3:0] c_sel = ~(4'b0001 << k);

    assign w_sample[k] = (r_settle == '0) && (r_an == c_sel);

    seg_digit_filter #(
      .STABLE_CNT (STABLE_CNT)
    ) u_filter (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_en     (w_sample[k]),
      .sym           (w_sym),
      .commit        (w_commit[k]),
      .sym_committed (w_csym[k])
    );
  end

  // Apply commits to value/ok/err and decide whether the result deserves an update pulse
  always_comb begin
    w_a_nxt   = r_a;
    w_ok_nxt  = r_ok;
    w_err_nxt = r_err;
    for (int k = 0; k < 4; k++) begin
      if (w_commit[k]) begin
        case (w_csym[k])
          SYM_ZERO: begin
            w_a_nxt[k]   = 1'b0;
            w_ok_nxt[k]  = 1'b1;
            w_err_nxt[k] = 1'b0;
          end
          SYM_ONE: begin
            w_a_nxt[k]   = 1'b1;
            w_ok_nxt[k]  = 1'b1;
            w_err_nxt[k] = 1'b0;
          end
          SYM_BLANK: begin
            w_ok_nxt[k]  = 1'b0;
            w_err_nxt[k] = 1'b0;
          end
          default: begin
            w_ok_nxt[k]  = 1'b0;
            w_err_nxt[k] = 1'b1;
          end
        endcase
      end
    end
    w_upd_nxt = (w_a_nxt != r_a) || ((&w_ok_nxt) && !(&r_ok));
  end

  // Output state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= 4'b0000;
      r_ok     <= 4'b0000;
      r_err    <= 4'b0000;
      r_update <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_ok     <= w_ok_nxt;
      r_err    <= w_err_nxt;
      r_update <= w_upd_nxt;
    end
  end

  assign a      = r_a;
  assign valid  = &r_ok;
  assign err    = r_err;
  assign update = r_update;

endmodule
`default_nettype wire
